// File: rtl/hci_multi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : hci_mem_intf
// Brief  : Single-channel TCDM request/response bundle shared by initiators
//          and targets of the HCI arbiter.
// Rev    : 1.0
// ============================================================================
interface hci_mem_intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int USER_W = 2
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_W-1:0]     add;
  logic                  wen;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     data;
  logic [ID_W-1:0]       id;
  logic [USER_W-1:0]     user;
  logic [DATA_W-1:0]     r_data;
  logic [ID_W-1:0]       r_id;
  logic [USER_W-1:0]     r_user;

  modport initiator (output req, add, wen, be, data, id, user,
                     input  gnt, r_data, r_id, r_user);
  modport target    (input  req, add, wen, be, data, id, user,
                     output gnt, r_data, r_id, r_user);
  modport master    (output req, add, wen, be, data, id, user,
                     input  gnt, r_data, r_id, r_user);
  modport slave     (input  req, add, wen, be, data, id, user,
                     output gnt, r_data, r_id, r_user);
endinterface
`default_nettype wire

// File: rtl/hci_multi_arbiter.sv
`default_nettype none
// ============================================================================
// Module : hci_multi_arbiter
// Brief  : Work-conserving arbiter of NB_IN multi-channel sides onto NB_CHAN
//          memory channels; starvation forcing built with
//          HCI_MULTI_ARBITER_STARVATION_EN.
// Rev    : 1.0
// ============================================================================
module hci_multi_arbiter #(
  parameter  int NB_IN   = 2,
  parameter  int NB_CHAN = 2,
  parameter  int STALL_W = 8,
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int ID_W    = 4,
  parameter  int USER_W  = 2,
  localparam int IW      = (NB_IN > 1) ? $clog2(NB_IN) : 1
) (
  input  wire                clk_i,
  input  wire                rst_i,
  input  wire                clear_i,
  input  wire                rr_mode_i,
  input  wire  [STALL_W-1:0] max_stall_i,
  hci_mem_intf.target        in  [NB_IN*NB_CHAN],
  hci_mem_intf.initiator     out [NB_CHAN],
  output logic [IW-1:0]      winner_o,
  output logic [NB_IN-1:0]   starve_o
);

  localparam int CW   = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;
  localparam int BE_W = DATA_W / 8;

  logic [NB_CHAN-1:0][NB_IN-1:0] w_req;
  logic [NB_CHAN-1:0][NB_IN-1:0] w_gnt;
  logic [ADDR_W-1:0]  w_add  [NB_IN][NB_CHAN];
  logic               w_wen  [NB_IN][NB_CHAN];
  logic [BE_W-1:0]    w_be   [NB_IN][NB_CHAN];
  logic [DATA_W-1:0]  w_data [NB_IN][NB_CHAN];
  logic [ID_W-1:0]    w_id   [NB_IN][NB_CHAN];
  logic [USER_W-1:0]  w_user [NB_IN][NB_CHAN];
  logic [NB_CHAN-1:0] w_out_gnt;
  logic [IW-1:0]      w_src  [NB_CHAN];
  logic [NB_IN-1:0]   w_active;
  logic [NB_IN-1:0]   w_starve;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      w_winner;
  logic               w_win_hit;

  for (genvar s = 0; s < NB_IN; s++) begin : g_side
    for (genvar c = 0; c < NB_CHAN; c++) begin : g_ch
      localparam int P = s * NB_CHAN + c;
      assign w_req[c][s]    = in[P].req;
      assign w_add[s][c]    = in[P].add;
      assign w_wen[s][c]    = in[P].wen;
      assign w_be[s][c]     = in[P].be;
      assign w_data[s][c]   = in[P].data;
      assign w_id[s][c]     = in[P].id;
      assign w_user[s][c]   = in[P].user;
      assign w_gnt[c][s]    = (w_src[c] == IW'(s)) && w_out_gnt[c];
      assign in[P].gnt      = w_gnt[c][s];
      assign in[P].r_data   = out[c].r_data;
      assign in[P].r_id     = out[c].r_id;
      assign in[P].r_user   = out[c].r_user;
    end
  end

  always_comb begin
    w_active = '0;
    for (int c = 0; c < NB_CHAN; c++) w_active = w_active | w_req[CW'(c)];
  end

  // Starving sides override the mode rule; otherwise scan from 0 or from rr_ptr.
  always_comb begin
    logic found;
    int   idx;
    w_winner = rr_mode_i ? r_rr_ptr : '0;
    found    = 1'b0;
    idx      = 0;
    for (int s = 0; s < NB_IN; s++) begin
      if (!found && w_starve[IW'(s)]) begin
        w_winner = IW'(s);
        found    = 1'b1;
      end
    end
    for (int k = 0; k < NB_IN; k++) begin
      idx = rr_mode_i ? int'(r_rr_ptr) + k : k;
      if (idx >= NB_IN) idx = idx - NB_IN;
      if (!found && w_active[IW'(idx)]) begin
        w_winner = IW'(idx);
        found    = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
    logic [IW-1:0] w_sel;

    // A channel the winner leaves idle goes to the next requester after it.
    always_comb begin
      logic found;
      int   idx;
      w_sel = w_winner;
      found = w_req[c][w_winner];
      idx   = 0;
      for (int k = 1; k < NB_IN; k++) begin
        idx = int'(w_winner) + k;
        if (idx >= NB_IN) idx = idx - NB_IN;
        if (!found && w_req[c][IW'(idx)]) begin
          w_sel = IW'(idx);
          found = 1'b1;
        end
      end
    end

    assign w_src[c]     = w_sel;
    assign w_out_gnt[c] = out[c].gnt;
    assign out[c].req   = w_req[c][w_sel];
    assign out[c].add   = w_add[w_sel][c];
    assign out[c].wen   = w_wen[w_sel][c];
    assign out[c].be    = w_be[w_sel][c];
    assign out[c].data  = w_data[w_sel][c];
    assign out[c].id    = w_id[w_sel][c];
    assign out[c].user  = w_user[w_sel][c];
  end

  always_comb begin
    w_win_hit = 1'b0;
    for (int c = 0; c < NB_CHAN; c++)
      w_win_hit = w_win_hit | (w_req[CW'(c)][w_winner] & w_gnt[CW'(c)][w_winner]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_rr_ptr <= '0;
    else if (clear_i)
      r_rr_ptr <= '0;
    else if (w_win_hit)
      r_rr_ptr <= (int'(w_winner) == NB_IN - 1) ? '0 : w_winner + 1'b1;
  end

`ifdef HCI_MULTI_ARBITER_STARVATION_EN
  logic [NB_IN-1:0] w_side_gnt;

  always_comb begin
    w_side_gnt = '0;
    for (int c = 0; c < NB_CHAN; c++) w_side_gnt = w_side_gnt | w_gnt[CW'(c)];
  end

  for (genvar s = 0; s < NB_IN; s++) begin : g_stall
    logic [STALL_W-1:0] r_stall_ctr;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
        r_stall_ctr <= '0;
      else if (clear_i)
        r_stall_ctr <= '0;
      else if (w_active[s] && !w_side_gnt[s]) begin
        if (r_stall_ctr != {STALL_W{1'b1}}) r_stall_ctr <= r_stall_ctr + 1'b1;
      end else
        r_stall_ctr <= '0;
    end

    assign w_starve[s] = (max_stall_i != '0) && (r_stall_ctr >= max_stall_i);
  end
`else
  logic w_unused_max_stall;
  assign w_unused_max_stall = ^max_stall_i;
  assign w_starve           = '0;
`endif

  assign winner_o = w_winner;
  assign starve_o = w_starve;

endmodule
`default_nettype wire

// File: tb/tb_hci_multi_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_hci_multi_arbiter
// Brief  : Directed and random checks of hci_multi_arbiter (3 sides x 2
//          channels) against a rule-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_hci_multi_arbiter;
  localparam int NB_IN   = 3;
  localparam int NB_CHAN = 2;
  localparam int STALL_W = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int USER_W  = 2;
  localparam int IW      = 2;
  localparam int BE_W    = DATA_W / 8;
  localparam int NP      = NB_IN * NB_CHAN;
  localparam int RW      = DATA_W + ID_W + USER_W;
  localparam int SAT     = (1 << STALL_W) - 1;
`ifdef HCI_MULTI_ARBITER_STARVATION_EN
  localparam bit STARV = 1'b1;
`else
  localparam bit STARV = 1'b0;
`endif

  logic clk;
  logic rst, clear, rr_mode;
  logic [STALL_W-1:0] max_stall;
  logic [IW-1:0]      winner;
  logic [NB_IN-1:0]   starve;

  logic               t_req  [NP];
  logic [ADDR_W-1:0]  t_add  [NP];
  logic               t_wen  [NP];
  logic [BE_W-1:0]    t_be   [NP];
  logic [DATA_W-1:0]  t_data [NP];
  logic [ID_W-1:0]    t_id   [NP];
  logic [USER_W-1:0]  t_user [NP];
  logic               t_gnt  [NP];
  logic [DATA_W-1:0]  t_rdata[NP];
  logic [ID_W-1:0]    t_rid  [NP];
  logic [USER_W-1:0]  t_ruser[NP];

  logic               o_req  [NB_CHAN];
  logic [ADDR_W-1:0]  o_add  [NB_CHAN];
  logic               o_wen  [NB_CHAN];
  logic [BE_W-1:0]    o_be   [NB_CHAN];
  logic [DATA_W-1:0]  o_data [NB_CHAN];
  logic [ID_W-1:0]    o_id   [NB_CHAN];
  logic [USER_W-1:0]  o_user [NB_CHAN];
  logic               o_gnt  [NB_CHAN];
  logic [DATA_W-1:0]  o_rdata[NB_CHAN];
  logic [ID_W-1:0]    o_rid  [NB_CHAN];
  logic [USER_W-1:0]  o_ruser[NB_CHAN];

  hci_mem_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) in_if  [NP] ();
  hci_mem_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) out_if [NB_CHAN] ();

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign in_if[p].req  = t_req[p];
    assign in_if[p].add  = t_add[p];
    assign in_if[p].wen  = t_wen[p];
    assign in_if[p].be   = t_be[p];
    assign in_if[p].data = t_data[p];
    assign in_if[p].id   = t_id[p];
    assign in_if[p].user = t_user[p];
    assign t_gnt[p]      = in_if[p].gnt;
    assign t_rdata[p]    = in_if[p].r_data;
    assign t_rid[p]      = in_if[p].r_id;
    assign t_ruser[p]    = in_if[p].r_user;
  end

  for (genvar c = 0; c < NB_CHAN; c++) begin : g_out
    assign o_req[c]         = out_if[c].req;
    assign o_add[c]         = out_if[c].add;
    assign o_wen[c]         = out_if[c].wen;
    assign o_be[c]          = out_if[c].be;
    assign o_data[c]        = out_if[c].data;
    assign o_id[c]          = out_if[c].id;
    assign o_user[c]        = out_if[c].user;
    assign out_if[c].gnt    = o_gnt[c];
    assign out_if[c].r_data = o_rdata[c];
    assign out_if[c].r_id   = o_rid[c];
    assign out_if[c].r_user = o_ruser[c];
  end

  hci_multi_arbiter #(
    .NB_IN(NB_IN), .NB_CHAN(NB_CHAN), .STALL_W(STALL_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .rr_mode_i(rr_mode),
    .max_stall_i(max_stall), .in(in_if), .out(out_if),
    .winner_o(winner), .starve_o(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: round-robin pointer and per-side stall counts.
  int m_ptr;
  int m_ctr [NB_IN];
  int e_win;
  int e_src [NB_CHAN];
  logic [NB_IN-1:0] e_starve;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit side_active(int s);
    bit a = 0;
    for (int c = 0; c < NB_CHAN; c++) if (t_req[s*NB_CHAN+c] === 1'b1) a = 1;
    return a;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    for (int s = 0; s < NB_IN; s++) m_ctr[s] = 0;
  endtask

  task automatic model_eval();
    int w;
    w = -1;
    for (int s = 0; s < NB_IN; s++)
      e_starve[s] = STARV && (max_stall != 0) && (m_ctr[s] >= int'(max_stall));
    for (int s = 0; s < NB_IN; s++) if (w < 0 && e_starve[s]) w = s;
    if (w < 0) begin
      for (int k = 0; k < NB_IN; k++) begin
        int cand;
        cand = rr_mode ? (m_ptr + k) % NB_IN : k;
        if (w < 0 && side_active(cand)) w = cand;
      end
    end
    if (w < 0) w = rr_mode ? m_ptr : 0;
    e_win = w;
    for (int c = 0; c < NB_CHAN; c++) begin
      e_src[c] = w;
      if (t_req[w*NB_CHAN+c] !== 1'b1) begin
        for (int k = NB_IN - 1; k >= 1; k--)
          if (t_req[((w + k) % NB_IN)*NB_CHAN+c] === 1'b1) e_src[c] = (w + k) % NB_IN;
      end
    end
  endtask

  task automatic model_clock();
    bit hit;
    hit = 0;
    if (rst || clear) begin
      model_reset();
    end else begin
      for (int s = 0; s < NB_IN; s++) begin
        bit got;
        got = 0;
        for (int c = 0; c < NB_CHAN; c++)
          if (e_src[c] == s && o_gnt[c]) begin
            got = 1;
            if (s == e_win && t_req[s*NB_CHAN+c]) hit = 1;
          end
        if (side_active(s) && !got) m_ctr[s] = (m_ctr[s] < SAT) ? m_ctr[s] + 1 : SAT;
        else m_ctr[s] = 0;
      end
      if (hit) m_ptr = (e_win + 1) % NB_IN;
    end
  endtask

  task automatic settle();
    logic [NP-1:0] g_obs, g_exp;
    #1;
    model_eval();
    chk("winner", 128'(winner), 128'(e_win));
    chk("starve", 128'(starve), 128'(e_starve));
    for (int c = 0; c < NB_CHAN; c++) begin
      int p;
      logic [127:0] rs_o, rs_e;
      p = e_src[c]*NB_CHAN + c;
      chk($sformatf("out%0d_fields", c),
          128'({o_req[c], o_add[c], o_wen[c], o_be[c], o_data[c], o_id[c], o_user[c]}),
          128'({t_req[p], t_add[p], t_wen[p], t_be[p], t_data[p], t_id[p], t_user[p]}));
      rs_o = '0;
      rs_e = '0;
      for (int s = 0; s < NB_IN; s++) begin
        rs_o = (rs_o << RW) | 128'({t_rdata[s*NB_CHAN+c], t_rid[s*NB_CHAN+c], t_ruser[s*NB_CHAN+c]});
        rs_e = (rs_e << RW) | 128'({o_rdata[c], o_rid[c], o_ruser[c]});
      end
      chk($sformatf("rsp%0d_bcast", c), rs_o, rs_e);
    end
    for (int p = 0; p < NP; p++) begin
      g_obs[p] = t_gnt[p];
      g_exp[p] = (e_src[p % NB_CHAN] == p / NB_CHAN) && o_gnt[p % NB_CHAN];
    end
    chk("gnt_vec", 128'(g_obs), 128'(g_exp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) t_req[p] = 1'b0;
    for (int c = 0; c < NB_CHAN; c++) o_gnt[c] = 1'b0;
  endtask

  task automatic rand_fields();
    for (int p = 0; p < NP; p++) begin
      t_add[p]  = $urandom;
      t_wen[p]  = 1'($urandom);
      t_be[p]   = BE_W'($urandom);
      t_data[p] = $urandom;
      t_id[p]   = ID_W'($urandom);
      t_user[p] = USER_W'($urandom);
    end
    for (int c = 0; c < NB_CHAN; c++) begin
      o_rdata[c] = $urandom;
      o_rid[c]   = ID_W'($urandom);
      o_ruser[c] = USER_W'($urandom);
    end
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int rr_seq [6];
    rr_seq = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1; clear = 1'b0; rr_mode = 1'b0; max_stall = '0;
    idle_inputs();
    rand_fields();
    model_reset();
    settle();
    chk("reset_winner", 128'(winner), 128'(0));
    chk("reset_starve", 128'(starve), 128'(0));
    tick();
    rst = 1'b0;

    // Fixed priority: sides 0 and 2 on ch0, side 0 always wins.
    rr_mode = 1'b0; max_stall = '0;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      t_req[0] = 1'b1; t_req[4] = 1'b1; o_gnt[0] = 1'b1; o_gnt[1] = 1'b1;
      settle();
      chk("fixed_s0_gnt", 128'(t_gnt[0]), 128'(1));
      chk("fixed_s2_gnt", 128'(t_gnt[4]), 128'(0));
      tick();
    end

    // Round robin: all sides on ch0 rotate 0,1,2,0,1,2.
    do_clear();
    rr_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      t_req[0] = 1'b1; t_req[2] = 1'b1; t_req[4] = 1'b1; o_gnt[0] = 1'b1;
      settle();
      chk("rr_seq", 128'(winner), 128'(rr_seq[i]));
      tick();
    end

    // Starvation: side 1 gets through every 4th cycle only when built in.
    do_clear();
    rr_mode = 1'b0; max_stall = 8'd3;
    for (int i = 1; i <= 8; i++) begin
      rand_fields();
      t_req[0] = 1'b1; t_req[2] = 1'b1; o_gnt[0] = 1'b1;
      settle();
      chk("starve_s1_gnt", 128'(t_gnt[2]), 128'(STARV && (i % 4 == 0)));
      chk("starve_flag1", 128'(starve[1]), 128'(STARV && (i % 4 == 0)));
      tick();
    end

    // Work conserving: disjoint channels both granted together.
    do_clear();
    max_stall = '0;
    rand_fields();
    t_req[0] = 1'b1; t_req[3] = 1'b1; o_gnt[0] = 1'b1; o_gnt[1] = 1'b1;
    settle();
    chk("wc_s0_ch0", 128'(t_gnt[0]), 128'(1));
    chk("wc_s1_ch1", 128'(t_gnt[3]), 128'(1));
    tick();

    // Saturation over 300 stalled cycles, then asynchronous reset.
    do_clear();
    rr_mode = 1'b1;
    t_req[2] = 1'b1; o_gnt[0] = 1'b1;
    step();
    max_stall = 8'd255;
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      t_req[0] = 1'b1; t_req[2] = 1'b1; o_gnt[0] = 1'b0;
      step();
    end
    settle();
    chk("sat_starve1", 128'(starve[1]), 128'(STARV));
    idle_inputs();
    max_stall = '0;
    settle();
    chk("ptr_before_rst", 128'(winner), 128'(2));
    rst = 1'b1;
    max_stall = 8'd255;
    model_reset();
    settle();
    chk("rst_winner", 128'(winner), 128'(0));
    chk("rst_starve", 128'(starve), 128'(0));
    tick();
    rst = 1'b0;

    // Random traffic with mode/threshold changes and occasional clears.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      for (int p = 0; p < NP; p++) t_req[p] = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < NB_CHAN; c++) o_gnt[c] = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
      if ($urandom_range(0, 15) == 0) max_stall = STALL_W'($urandom_range(0, 5));
      step();
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
